// File: rtl/udp_test_pkg.sv
// Shared definitions for the UDP test-pattern generator and its receive-side checker:
// checker FSM encoding, pattern defaults and the pattern byte helper.
package udp_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int EXP_LEN_DEF = 100;
  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 1024;

  // Byte n of a generator payload is n modulo 256.
  function automatic logic [7:0] pattern_byte(input logic [15:0] idx);
    return idx[7:0];
  endfunction

endpackage

// File: rtl/udp_recv_checker_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over a concurrent increment.
module sat_counter #(
  parameter int P_W = 32
) (
  input  logic           w_user_clk,
  input  logic           w_user_rst,
  input  logic           clr,
  input  logic           inc,
  output logic [P_W-1:0] cnt
);

  logic [P_W-1:0] cnt_reg;

  always_ff @(posedge w_user_clk or posedge w_user_rst) begin
    if (w_user_rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/udp_recv_checker.sv
// Checks UDP receive payloads against the generator pattern (0,1,2,... of fixed length)
// and keeps per-packet status, good/bad packet counters and a sticky error flag.
module udp_recv_checker
  import udp_test_pkg::*;
#(
  parameter int P_EXP_LEN = EXP_LEN_DEF,
  parameter int P_CNT_W   = CNT_W_DEF,
  parameter int P_TIMEOUT = TIMEOUT_DEF
) (
  input  logic               w_user_clk,
  input  logic               w_user_rst,
  input  logic [7:0]         i_recv_udp_data,
  input  logic [15:0]        i_recv_udp_len,
  input  logic               i_recv_udp_last,
  input  logic               i_recv_udp_valid,
  input  logic               i_clear,
  output logic               o_pkt_done,
  output logic               o_pkt_ok,
  output logic [P_CNT_W-1:0] o_good_cnt,
  output logic [P_CNT_W-1:0] o_bad_cnt,
  output logic               o_err_sticky
);

  localparam int                IDLE_W     = $clog2(P_TIMEOUT + 1);
  localparam logic [15:0]       EXP_LEN16  = 16'(P_EXP_LEN);
  localparam logic [IDLE_W-1:0] TIMEOUT_M1 = IDLE_W'(P_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [15:0]       bcnt_reg, bcnt_next;
  logic [15:0]       len_reg, len_next;
  logic              err_reg, err_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic              done_reg, done_next;
  logic              ok_reg, ok_next;
  logic              sticky_reg, sticky_next;
  logic [15:0]       bcnt_inc;
  logic              beat_err;
  logic              first_err;

  always_ff @(posedge w_user_clk or posedge w_user_rst) begin
    if (w_user_rst) begin
      state_reg  <= ST_IDLE;
      bcnt_reg   <= '0;
      len_reg    <= '0;
      err_reg    <= 1'b0;
      idle_reg   <= '0;
      done_reg   <= 1'b0;
      ok_reg     <= 1'b0;
      sticky_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      bcnt_reg   <= bcnt_next;
      len_reg    <= len_next;
      err_reg    <= err_next;
      idle_reg   <= idle_next;
      done_reg   <= done_next;
      ok_reg     <= ok_next;
      sticky_reg <= sticky_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bcnt_next  = bcnt_reg;
    len_next   = len_reg;
    err_next   = err_reg;
    idle_next  = idle_reg;
    done_next  = 1'b0;
    ok_next    = 1'b0;
    bcnt_inc   = (bcnt_reg == 16'hFFFF) ? bcnt_reg : bcnt_reg + 16'd1;
    beat_err   = (i_recv_udp_data != pattern_byte(bcnt_reg));
    first_err  = (i_recv_udp_data != pattern_byte(16'd0));

    case (state_reg)
      ST_RECV: begin
        if (i_recv_udp_valid) begin
          idle_next = '0;
          bcnt_next = bcnt_inc;
          err_next  = err_reg | beat_err;
          if (i_recv_udp_last) begin
            state_next = ST_REPORT;
            done_next  = 1'b1;
            ok_next    = !(err_reg | beat_err) && (bcnt_inc == EXP_LEN16) &&
                         (len_reg == EXP_LEN16);
          end
        end else if (idle_reg == TIMEOUT_M1) begin
          // Truncated packet: report it as a failure and wait for a fresh first beat.
          state_next = ST_REPORT;
          done_next  = 1'b1;
          idle_next  = '0;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end

      default: begin
        // IDLE and REPORT both accept the first beat of a packet.
        state_next = ST_IDLE;
        if (i_recv_udp_valid) begin
          len_next  = i_recv_udp_len;
          bcnt_next = 16'd1;
          err_next  = first_err;
          idle_next = '0;
          if (i_recv_udp_last) begin
            state_next = ST_REPORT;
            done_next  = 1'b1;
            ok_next    = !first_err && (EXP_LEN16 == 16'd1) && (i_recv_udp_len == EXP_LEN16);
          end else begin
            state_next = ST_RECV;
          end
        end
      end
    endcase
  end

  always_comb begin
    sticky_next = sticky_reg;
    if (i_clear) begin
      sticky_next = 1'b0;
    end else if (done_reg && !ok_reg) begin
      sticky_next = 1'b1;
    end
  end

  // Index 0 counts good packets, index 1 bad ones; both update in the REPORT cycle.
  logic [1:0]         cnt_inc;
  logic [P_CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = done_reg & ok_reg;
  assign cnt_inc[1] = done_reg & ~ok_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(
        .P_W (P_CNT_W)
      ) u_sat_counter (
        .w_user_clk (w_user_clk),
        .w_user_rst (w_user_rst),
        .clr        (i_clear),
        .inc        (cnt_inc[gi]),
        .cnt        (cnt_val[gi])
      );
    end
  endgenerate

  assign o_pkt_done   = done_reg;
  assign o_pkt_ok     = ok_reg;
  assign o_good_cnt   = cnt_val[0];
  assign o_bad_cnt    = cnt_val[1];
  assign o_err_sticky = sticky_reg;

endmodule
